// File: rtl/chunk_writer_pkg.sv
// Shared types and header field positions for the SPI-to-panel-memory chunk writer.
package chunk_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR0 = 2'd1,
    HDR1 = 2'd2,
    DATA = 2'd3
  } state_t;

  localparam int PANEL_MSB   = 7;
  localparam int PANEL_LSB   = 6;
  localparam int ROW_MSB     = 3;
  localparam int ROW_LSB     = 0;
  localparam int CHUNK_MSB   = 3;
  localparam int CHUNK_BYTES = 4;

endpackage

// File: rtl/chunk_writer_spi_bit_sampler.sv
// SPI pin synchronizers with sclk rising-edge and cs_n edge detection.
module spi_bit_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  input  logic spi_cs_n,
  output logic bit_valid,
  output logic bit_value,
  output logic frame_start,
  output logic frame_end
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_q;
  logic                   cs_q;
  logic                   sclk_s;
  logic                   cs_s;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // cs_n chain resets to the deasserted level so reset never looks like a frame edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign bit_valid   = sclk_s & ~sclk_q & ~cs_s;
  assign bit_value   = mosi_sync[SYNC_STAGES-1];
  assign frame_start = cs_q & ~cs_s;
  assign frame_end   = ~cs_q & cs_s;

endmodule

// File: rtl/chunk_writer.sv
// SPI mode-0 slave: 2-byte header then one 32-bit panel-memory write per 4 payload bytes.
// Build option: define CHUNK_WRITER_LIMIT_EN to stop writing after chunk index 15.
module chunk_writer
  import chunk_writer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic [31:0] chunk_data,
  output logic [3:0]  chunk_addr,
  output logic        chunk_write_enable,
  output logic [3:0]  row_addr,
  output logic [1:0]  panel_addr,
  output logic        busy,
  output logic        frame_error,
  output logic [1:0]  state_dbg
);

  logic        bit_valid, bit_value, frame_start, frame_end;
  state_t      state, state_nxt;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        byte_done;
  logic [23:0] acc;
  logic [1:0]  byte_cnt;
  logic [3:0]  chunk_idx;
  logic        chunk_done, chunk_drop, drop_err, hdr_err, data_err;

  spi_bit_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .bit_valid   (bit_valid),
    .bit_value   (bit_value),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_end) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (frame_start) state_nxt = HDR0;
        HDR0:    if (byte_done)   state_nxt = HDR1;
        HDR1:    if (byte_done)   state_nxt = DATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // byte_done is registered so it coincides with the completed byte sitting in shreg.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else if (frame_end) begin
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else if (bit_valid) begin
      shreg     <= {shreg[6:0], bit_value};
      bit_cnt   <= bit_cnt + 3'd1;
      byte_done <= (bit_cnt == 3'd7);
    end else begin
      byte_done <= 1'b0;
    end
  end

  assign chunk_done = byte_done && (state == DATA) && (byte_cnt == 2'(CHUNK_BYTES - 1));

`ifdef CHUNK_WRITER_LIMIT_EN
  logic limit_hit, dropped;
  assign chunk_drop = chunk_done && limit_hit;
  assign drop_err   = dropped || chunk_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit_hit <= 1'b0;
      dropped   <= 1'b0;
    end else if (frame_end) begin
      limit_hit <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      if (chunk_done && !limit_hit && chunk_idx == 4'd15) limit_hit <= 1'b1;
      if (chunk_drop) dropped <= 1'b1;
    end
  end
`else
  assign chunk_drop = 1'b0;
  assign drop_err   = 1'b0;
`endif

  // A byte completing on the cs_n-rise cycle still counts toward the byte counter,
  // so a finished chunk closes the frame cleanly while a fresh partial one does not.
  assign hdr_err  = ((state == HDR0) && (bit_cnt != 3'd0 || byte_done)) ||
                    ((state == HDR1) && (bit_cnt != 3'd0));
  assign data_err = (state == DATA) && ((byte_cnt + 2'(byte_done)) != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc                <= '0;
      byte_cnt           <= '0;
      chunk_idx          <= '0;
      chunk_data         <= '0;
      chunk_addr         <= '0;
      chunk_write_enable <= 1'b0;
      row_addr           <= '0;
      panel_addr         <= '0;
      frame_error        <= 1'b0;
    end else begin
      chunk_write_enable <= 1'b0;
      frame_error        <= frame_end && ((bit_cnt != 3'd0) || hdr_err || data_err || drop_err);
      if (state == HDR0 && byte_done) begin
        panel_addr <= shreg[PANEL_MSB:PANEL_LSB];
        row_addr   <= shreg[ROW_MSB:ROW_LSB];
      end
      if (state == HDR1 && byte_done) begin
        chunk_idx <= shreg[CHUNK_MSB:0];
      end
      if (state == DATA && byte_done) begin
        acc <= {acc[15:0], shreg};
      end
      if (chunk_done && !chunk_drop) begin
        chunk_data         <= {acc, shreg};
        chunk_addr         <= chunk_idx;
        chunk_write_enable <= 1'b1;
        chunk_idx          <= chunk_idx + 4'd1;
      end
      if (frame_end)                      byte_cnt <= '0;
      else if (state == DATA && byte_done) byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_chunk_writer.sv
// Directed bench for chunk_writer: SPI frames driven bit by bit, strobes logged and checked.
module tb_chunk_writer;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic [31:0] chunk_data;
  logic [3:0]  chunk_addr;
  logic        chunk_write_enable;
  logic [3:0]  row_addr;
  logic [1:0]  panel_addr;
  logic        busy;
  logic        frame_error;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rise = 0;
  int ferr_cnt  = 0;

  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_addr_q[$];
  int          wr_cyc_q[$];
  logic [31:0] exp_q[$];
  logic [3:0]  exp_addr_q[$];

  chunk_writer #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .spi_sclk           (spi_sclk),
    .spi_mosi           (spi_mosi),
    .spi_cs_n           (spi_cs_n),
    .chunk_data         (chunk_data),
    .chunk_addr         (chunk_addr),
    .chunk_write_enable (chunk_write_enable),
    .row_addr           (row_addr),
    .panel_addr         (panel_addr),
    .busy               (busy),
    .frame_error        (frame_error),
    .state_dbg          (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor: log strobes and error pulses 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (chunk_write_enable === 1'b1) begin
      wr_data_q.push_back(chunk_data);
      wr_addr_q.push_back(chunk_addr);
      wr_cyc_q.push_back(cyc);
    end
    if (frame_error === 1'b1) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(3);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      wait_clk(HALF);
      spi_sclk  = 1'b1;
      last_rise = cyc;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic clear_logs();
    wr_data_q.delete();
    wr_addr_q.delete();
    wr_cyc_q.delete();
    exp_q.delete();
    exp_addr_q.delete();
    ferr_cnt = 0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 32'(wr_data_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && wr_data_q.size() > 0) begin
      check({tag, "_data"}, wr_data_q.pop_front(), exp_q.pop_front());
      check({tag, "_addr"}, 32'(wr_addr_q.pop_front()), 32'(exp_addr_q.pop_front()));
    end
  endtask

  initial begin
    do_reset();
    check("rst_cwe",   32'(chunk_write_enable), 32'd0);
    check("rst_data",  chunk_data, 32'd0);
    check("rst_addr",  32'(chunk_addr), 32'd0);
    check("rst_row",   32'(row_addr), 32'd0);
    check("rst_panel", 32'(panel_addr), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ferr",  32'(frame_error), 32'd0);

    // single chunk
    clear_logs();
    cs_low();
    check("t1_busy", 32'(busy), 32'd1);
    spi_byte(8'h8A); spi_byte(8'h03);
    spi_byte(8'hDE); spi_byte(8'hAD); spi_byte(8'hBE); spi_byte(8'hEF);
    wait_clk(6);
    if (wr_cyc_q.size() > 0) check("t1_latency", 32'(wr_cyc_q[0] - last_rise), 32'(SYNC_STAGES + 2));
    else check("t1_latency_seen", 32'(wr_cyc_q.size()), 32'd1);
    cs_high();
    exp_q.push_back(32'hDEADBEEF); exp_addr_q.push_back(4'd3);
    check_writes("t1");
    check("t1_row",   32'(row_addr), 32'hA);
    check("t1_panel", 32'(panel_addr), 32'd2);
    check("t1_ferr",  32'(ferr_cnt), 32'd0);
    check("t1_idle",  32'(busy), 32'd0);
    check("t1_hold",  chunk_data, 32'hDEADBEEF);

    // index wrap at 15
    clear_logs();
    cs_low();
    spi_byte(8'h45); spi_byte(8'h0F);
    spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_byte(8'h44);
    spi_byte(8'h55); spi_byte(8'h66); spi_byte(8'h77); spi_byte(8'h88);
    cs_high();
    exp_q.push_back(32'h11223344); exp_addr_q.push_back(4'd15);
`ifdef CHUNK_WRITER_LIMIT_EN
    check_writes("t2");
    check("t2_ferr", 32'(ferr_cnt), 32'd1);
    check("t2_hold", chunk_data, 32'h11223344);
`else
    exp_q.push_back(32'h55667788); exp_addr_q.push_back(4'd0);
    check_writes("t2");
    check("t2_ferr", 32'(ferr_cnt), 32'd0);
`endif
    check("t2_row",   32'(row_addr), 32'd5);
    check("t2_panel", 32'(panel_addr), 32'd1);

    // partial trailing chunk discarded
    clear_logs();
    cs_low();
    spi_byte(8'h00); spi_byte(8'h05);
    spi_byte(8'h01); spi_byte(8'h02); spi_byte(8'h03); spi_byte(8'h04);
    spi_byte(8'h05); spi_byte(8'h06);
    cs_high();
    exp_q.push_back(32'h01020304); exp_addr_q.push_back(4'd5);
    check_writes("t3");
    check("t3_ferr", 32'(ferr_cnt), 32'd1);
    check("t3_hold", chunk_data, 32'h01020304);

    // aborted header after 5 bits, then a normal frame
    clear_logs();
    cs_low();
    spi_bits(8'hFF, 5);
    cs_high();
    check_writes("t4a");
    check("t4a_ferr", 32'(ferr_cnt), 32'd1);
    check("t4a_busy", 32'(busy), 32'd0);
    clear_logs();
    cs_low();
    spi_byte(8'hC1); spi_byte(8'h07);
    spi_byte(8'hA1); spi_byte(8'hB2); spi_byte(8'hC3); spi_byte(8'hD4);
    cs_high();
    exp_q.push_back(32'hA1B2C3D4); exp_addr_q.push_back(4'd7);
    check_writes("t4b");
    check("t4b_ferr",  32'(ferr_cnt), 32'd0);
    check("t4b_row",   32'(row_addr), 32'd1);
    check("t4b_panel", 32'(panel_addr), 32'd3);

    // zero-length and header-only frames are not errors
    clear_logs();
    cs_low();
    cs_high();
    cs_low();
    spi_byte(8'h3F); spi_byte(8'h09);
    cs_high();
    check_writes("t5");
    check("t5_ferr", 32'(ferr_cnt), 32'd0);
    check("t5_row",  32'(row_addr), 32'hF);
    check("t5_panel", 32'(panel_addr), 32'd0);

    // reset mid-payload
    clear_logs();
    cs_low();
    spi_byte(8'h81); spi_byte(8'h02);
    spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33);
    reset_n = 1'b0;
    #2;
    check("t6_rst_data",  chunk_data, 32'd0);
    check("t6_rst_addr",  32'(chunk_addr), 32'd0);
    check("t6_rst_row",   32'(row_addr), 32'd0);
    check("t6_rst_panel", 32'(panel_addr), 32'd0);
    check("t6_rst_busy",  32'(busy), 32'd0);
    check("t6_rst_cwe",   32'(chunk_write_enable), 32'd0);
    spi_cs_n = 1'b1;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(3);
    check_writes("t6a");
    cs_low();
    spi_byte(8'h81); spi_byte(8'h02);
    spi_byte(8'hCA); spi_byte(8'hFE); spi_byte(8'hF0); spi_byte(8'h0D);
    cs_high();
    exp_q.push_back(32'hCAFEF00D); exp_addr_q.push_back(4'd2);
    check_writes("t6b");
    check("t6_ferr",  32'(ferr_cnt), 32'd0);
    check("t6_row",   32'(row_addr), 32'd1);
    check("t6_panel", 32'(panel_addr), 32'd2);

    // sclk activity with cs_n high is ignored
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      spi_mosi = 1'(i);
      spi_sclk = ~spi_sclk;
      wait_clk(HALF);
    end
    check("t7_quiet_busy", 32'(busy), 32'd0);
    cs_low();
    spi_byte(8'h40); spi_byte(8'h00);
    spi_byte(8'h01); spi_byte(8'h23); spi_byte(8'h45); spi_byte(8'h67);
    wait_clk(6);
    if (wr_cyc_q.size() > 0) check("t7_latency", 32'(wr_cyc_q[0] - last_rise), 32'(SYNC_STAGES + 2));
    else check("t7_latency_seen", 32'(wr_cyc_q.size()), 32'd1);
    cs_high();
    exp_q.push_back(32'h01234567); exp_addr_q.push_back(4'd0);
    check_writes("t7");
    check("t7_ferr",  32'(ferr_cnt), 32'd0);
    check("t7_row",   32'(row_addr), 32'd0);
    check("t7_panel", 32'(panel_addr), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chunk_writer.md
Name: chunk_writer

Overview:
- SPI-mode-0 slave. Receives LED frame data from the host microcontroller and converts it into the panel-memory write bus consumed by the LED controller: chunk_data, chunk_addr, chunk_write_enable, row_addr and panel_addr.
- Sits between the board SPI pins and led_controller.
- Decodes a 2-byte header, then issues one 32-bit chunk write per 4 payload bytes.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on spi_sclk, spi_mosi and spi_cs_n (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x spi_sclk frequency.
- reset_n  in  1  reset; asynchronous, active-low.
- spi_sclk  in  1  SPI clock; idles low; data sampled on rising edge.
- spi_mosi  in  1  SPI data; MSB first.
- spi_cs_n  in  1  SPI chip select; active-low; frames a transfer.
- chunk_data  out  32  assembled chunk; first received byte in [31:24].
- chunk_addr  out  4  chunk index within the row.
- chunk_write_enable  out  1  one-clk write strobe.
- row_addr  out  4  target row from header.
- panel_addr  out  2  target panel from header.
- busy  out  1  high while a frame is open (synchronized cs_n low).
- frame_error  out  1  one-clk pulse on a malformed frame.

Behaviour:
- Reset: all outputs 0; state IDLE; shift register, bit counter and byte counter cleared.
- Input sync: spi_sclk, spi_mosi and spi_cs_n each pass through SYNC_STAGES flops.
  - sclk_rise = synced sclk is 1 and was 0 on the previous clk.
  - A bit is captured only on sclk_rise while synced cs_n is low.
- Bit assembly: 8-bit shift register, MSB first; 3-bit counter.
  - byte_done is asserted on the clk cycle of the 8th capture; the counter wraps 7->0.
- States:
  - IDLE: on synced cs_n falling -> HDR0; busy=1.
  - HDR0: on byte_done -> latch panel_addr=byte[7:6], row_addr=byte[3:0]; byte[5:4] ignored -> HDR1.
  - HDR1: on byte_done -> latch starting chunk index = byte[3:0]; byte[7:4] ignored -> DATA.
  - DATA: each byte_done shifts the byte into a 32-bit accumulator (new byte enters [7:0]); 2-bit byte counter increments.
- Chunk write: on the 4th byte_done of a chunk:
  - The clk cycle after, chunk_data is loaded with the accumulator, chunk_addr with the current index, and chunk_write_enable=1 for exactly one clk.
  - The index then increments modulo 16 (15->0 wraps) unless CHUNK_WRITER_LIMIT_EN is defined.
  - Latency is fixed: strobe one clk after the byte_done cycle, i.e. SYNC_STAGES+2 clk after the final spi_sclk rising edge at the pin.
- Output hold: chunk_data, chunk_addr, row_addr and panel_addr hold their values between writes; they change only on header latch or write load.
- Frame end: synced cs_n rising from any state -> IDLE, busy=0, bit and byte counters cleared. A partial chunk is discarded, never written.
- frame_error: one-clk pulse on the cs_n-rising cycle if any of:
  - bit counter != 0;
  - state is HDR0 or HDR1 having captured at least one bit;
  - DATA byte counter != 0.
- Error scope: a zero-length frame (cs_n low then high with no bits) gives no error. A header-only frame gives no error and no writes.
- Simultaneous events: if byte_done completing a chunk and cs_n rising land in the same clk, the write still issues and no error is flagged.
- Out-of-frame edges: sclk edges while cs_n is high are ignored.
- Reset mid-frame: immediate return to reset values; no write strobe.

Optional Feature:
- Macro: CHUNK_WRITER_LIMIT_EN.
- Defined:
  - After the write to chunk index 15, further complete chunks in the same frame are dropped: no strobe, chunk outputs unchanged.
  - frame_error pulses at frame end if any chunk was dropped.
- Undefined: the index wraps 15->0 and writes continue.

Decomposition:
- chunk_writer_pkg holds:
  - state enum (IDLE, HDR0, HDR1, DATA);
  - header field positions (PANEL_MSB=7, PANEL_LSB=6, ROW_MSB=3, ROW_LSB=0, CHUNK_MSB=3);
  - CHUNK_BYTES=4.
- One sub-module, spi_bit_sampler: synchronizers plus sclk rising-edge and cs_n edge detection. Outputs bit_valid, bit_value, frame_start and frame_end.

Test Plan:
- Header 0x8A, 0x03, payload DE AD BE EF -> one strobe with panel_addr=2, row_addr=10, chunk_addr=3, chunk_data=0xDEADBEEF; no frame_error.
- Header 0x45, 0x0F, 8 payload bytes 11223344 55667788 -> strobes at chunk_addr 15 (0x11223344) then 0 (0x55667788).
  - With CHUNK_WRITER_LIMIT_EN: only the first strobe, plus a frame_error pulse at cs_n rise.
- Header plus 6 payload bytes, then cs_n high -> one strobe; the partial chunk is discarded; frame_error pulses once.
- cs_n rises after 5 bits of HDR0 -> no strobe, frame_error pulse, busy=0. A following valid frame writes normally.
- reset_n asserted after 3 payload bytes -> all outputs 0 immediately; no strobe. After reset release, a new frame produces correct writes.
- sclk toggled 16 times with cs_n high, then a valid frame -> the toggles are ignored and the write timing is exactly SYNC_STAGES+2 clk after the last sclk rise.
